// File: rtl/lif_scheduler.sv
// Time-multiplexed leaky integrate-and-fire neurons; one neuron per cycle, done NUM_NEURONS+1 cycles after start.
// Backpressure: spike FIFO drains via spike_valid/spike_ready; pushes to a full FIFO are dropped into sticky overflow.
// Define LIF_ADAPT_EN to compile in per-neuron threshold adaptation.

// Spike-event FIFO: a push is accepted while full if a pop happens on the same edge.
// Latency: head visible the cycle after push. Backpressure: pop only when not empty.
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
module lif_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         empty,
    output logic         full
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wp;
    logic [PW-1:0] rp;
    logic [PW:0]   cnt;
    logic          do_pop;
    logic          do_push;

    assign empty   = (cnt == '0);
    assign full    = (cnt == FULL_CNT);
    assign head    = mem[rp];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (do_push) begin
                mem[wp] <= push_data;
                wp      <= wp + 1'b1;
            end
            if (do_pop) rp <= rp + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

module lif_scheduler #(
    parameter int NUM_NEURONS = 4,
    parameter int BASE_THRESH = 50,
    parameter int INIT_THRESH = 250,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           cur_valid,
    output logic                           cur_ready,
    input  logic [$clog2(NUM_NEURONS)-1:0] cur_addr,
    input  logic [7:0]                     cur_data,
    input  logic                           start,
    output logic                           busy,
    output logic                           done,
    output logic                           spike_valid,
    input  logic                           spike_ready,
    output logic [$clog2(NUM_NEURONS)-1:0] spike_id,
    output logic                           overflow,
    input  logic [$clog2(NUM_NEURONS)-1:0] rd_addr,
    output logic [7:0]                     rd_state,
    output logic [7:0]                     rd_thresh
);
    localparam int AW = $clog2(NUM_NEURONS);
    localparam logic [AW-1:0] LAST = AW'(NUM_NEURONS - 1);
`ifdef LIF_ADAPT_EN
    localparam bit ADAPT = 1'b1;
`else
    localparam bit ADAPT = 1'b0;
`endif
    localparam logic [7:0] BASE_T     = 8'(BASE_THRESH);
    localparam logic [7:0] RST_THRESH = ADAPT ? 8'(INIT_THRESH) : 8'(BASE_THRESH);

    typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DONE} fsm_t;

    fsm_t          fsm;
    logic [AW-1:0] idx;
    logic [7:0]    cur_mem [NUM_NEURONS];
    logic [7:0]    st_mem  [NUM_NEURONS];

    logic          wr_fire;
    logic          pop_fire;
    logic          fifo_full;
    logic          fifo_empty;
    logic [7:0]    upd_cur;
    logic [7:0]    upd_state;
    logic [7:0]    upd_thresh;
    logic          upd_spike;
    logic [11:0]   leak;
    logic [11:0]   sum;
    logic [7:0]    next_state;

    assign cur_ready   = (fsm == S_IDLE);
    assign busy        = (fsm != S_IDLE);
    assign done        = (fsm == S_DONE);
    assign wr_fire     = cur_valid && cur_ready;
    assign spike_valid = !fifo_empty;
    assign pop_fire    = spike_valid && spike_ready;

    // Leak of 14/16 on the pre-update state, integrated with the held current.
    assign upd_cur    = cur_mem[idx];
    assign upd_state  = st_mem[idx];
    assign upd_spike  = (fsm == S_SWEEP) && (upd_state >= upd_thresh);
    assign leak       = ({4'd0, upd_state} * 12'd14) >> 4;
    assign sum        = {4'd0, upd_cur} + leak;
    assign next_state = (sum > 12'd255) ? 8'hFF : sum[7:0];
    assign rd_state   = st_mem[rd_addr];

`ifdef LIF_ADAPT_EN
    logic [7:0] th_mem [NUM_NEURONS];
    logic [8:0] th_inc;

    assign upd_thresh = th_mem[idx];
    assign rd_thresh  = th_mem[rd_addr];
    assign th_inc     = {1'b0, upd_thresh} + {3'd0, upd_cur[7:2]};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_NEURONS; i++) th_mem[i] <= RST_THRESH;
        end else if (fsm == S_SWEEP) begin
            if (upd_spike) begin
                if (upd_thresh < 8'd170) th_mem[idx] <= th_inc[8] ? 8'hFF : th_inc[7:0];
            end else if (upd_thresh > BASE_T) begin
                th_mem[idx] <= upd_thresh - 8'd1;
            end
        end
    end
`else
    assign upd_thresh = RST_THRESH;
    assign rd_thresh  = BASE_T;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fsm      <= S_IDLE;
            idx      <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < NUM_NEURONS; i++) begin
                cur_mem[i] <= '0;
                st_mem[i]  <= '0;
            end
        end else begin
            // Writes land on the start edge too, so the sweep sees the new current.
            if (wr_fire) cur_mem[cur_addr] <= cur_data;
            case (fsm)
                S_IDLE: begin
                    if (start) begin
                        fsm <= S_SWEEP;
                        idx <= '0;
                    end
                end
                S_SWEEP: begin
                    st_mem[idx] <= next_state;
                    if (idx == LAST) begin
                        fsm <= S_DONE;
                        idx <= '0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                S_DONE:  fsm <= S_IDLE;
                default: fsm <= S_IDLE;
            endcase
            if (upd_spike && fifo_full && !pop_fire) overflow <= 1'b1;
        end
    end

    lif_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (AW)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (upd_spike),
        .push_data (idx),
        .pop       (spike_ready),
        .head      (spike_id),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );
endmodule

// File: tb/tb_lif_scheduler.sv
// Self-checking bench for lif_scheduler: directed tables, corner sequences and a random run against a queue model.
module tb_lif_scheduler;
    localparam int N     = 4;
    localparam int DEPTH = 4;
    localparam int BASE  = 50;
    localparam int INIT  = 250;
    localparam int AW    = 2;
`ifdef LIF_ADAPT_EN
    localparam int TH0 = INIT;
`else
    localparam int TH0 = BASE;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          cur_valid = 1'b0;
    logic [AW-1:0] cur_addr = '0;
    logic [7:0]    cur_data = '0;
    logic          start = 1'b0;
    logic          spike_ready = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic          cur_ready, busy, done, spike_valid, overflow;
    logic [AW-1:0] spike_id;
    logic [7:0]    rd_state, rd_thresh;

    always #5 clk = ~clk;

    lif_scheduler #(
        .NUM_NEURONS (N),
        .BASE_THRESH (BASE),
        .INIT_THRESH (INIT),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cur_valid   (cur_valid),
        .cur_ready   (cur_ready),
        .cur_addr    (cur_addr),
        .cur_data    (cur_data),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .spike_valid (spike_valid),
        .spike_ready (spike_ready),
        .spike_id    (spike_id),
        .overflow    (overflow),
        .rd_addr     (rd_addr),
        .rd_state    (rd_state),
        .rd_thresh   (rd_thresh)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: m_pos = -1 idle, 0..N-1 next neuron to update, N the done cycle.
    int m_cur [N];
    int m_st  [N];
    int m_th  [N];
    int m_q   [$];
    int m_pos = -1;
    int m_ovf = 0;
    int popped [$];

    typedef struct {
        int cur;
        int sweeps;
        int exp_state;
        int exp_spikes;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        int s, t, c, sp;
        if (!reset_n) begin
            for (int i = 0; i < N; i++) begin
                m_cur[i] = 0;
                m_st[i]  = 0;
                m_th[i]  = TH0;
            end
            m_q.delete();
            m_pos = -1;
            m_ovf = 0;
        end else begin
            if (m_q.size() > 0 && spike_ready) void'(m_q.pop_front());
            if (m_pos < 0) begin
                if (cur_valid) m_cur[cur_addr] = cur_data;
                if (start) m_pos = 0;
            end else if (m_pos < N) begin
                s  = m_st[m_pos];
                t  = m_th[m_pos];
                c  = m_cur[m_pos];
                sp = (s >= t) ? 1 : 0;
                m_st[m_pos] = (c + (s * 14) / 16 > 255) ? 255 : c + (s * 14) / 16;
`ifdef LIF_ADAPT_EN
                if (sp != 0) begin
                    if (t < 170) m_th[m_pos] = (t + c / 4 > 255) ? 255 : t + c / 4;
                end else if (t > BASE) begin
                    m_th[m_pos] = t - 1;
                end
`endif
                if (sp != 0) begin
                    if (m_q.size() < DEPTH) m_q.push_back(m_pos);
                    else m_ovf = 1;
                end
                m_pos++;
            end else begin
                m_pos = -1;
            end
        end
    endtask

    task automatic tick();
        if (spike_valid && spike_ready) popped.push_back(int'(spike_id));
        model_edge();
        @(posedge clk);
        #1;
        chk("busy", int'(busy), (m_pos >= 0) ? 1 : 0);
        chk("done", int'(done), (m_pos == N) ? 1 : 0);
        chk("cur_ready", int'(cur_ready), (m_pos < 0) ? 1 : 0);
        chk("spike_valid", int'(spike_valid), (m_q.size() > 0) ? 1 : 0);
        if (m_q.size() > 0) chk("spike_id", int'(spike_id), m_q[0]);
        chk("overflow", int'(overflow), m_ovf);
        chk("rd_state", int'(rd_state), m_st[rd_addr]);
        chk("rd_thresh", int'(rd_thresh), m_th[rd_addr]);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        cur_valid = 1'b0;
        start = 1'b0;
        spike_ready = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        popped.delete();
    endtask

    task automatic write(input int a, input int d);
        cur_valid = 1'b1;
        cur_addr = AW'(a);
        cur_data = 8'(d);
        tick();
        cur_valid = 1'b0;
    endtask

    task automatic sweep();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (N + 1) tick();
    endtask

    task automatic drain();
        spike_ready = 1'b1;
        repeat (DEPTH + 1) tick();
        spike_ready = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [6];
        tbl[0] = '{100, 1, 100, 0};
        tbl[1] = '{100, 2, 187, 1};
        tbl[2] = '{100, 3, 255, 2};
        tbl[3] = '{20,  4,  65, 1};
        tbl[4] = '{200, 2, 255, 1};
        tbl[5] = '{50,  2,  93, 1};

        #1;
        do_reset();
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_cur_ready", int'(cur_ready), 1);
        chk("rst_spike_valid", int'(spike_valid), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_state", int'(rd_state), 0);
        chk("rst_thresh", int'(rd_thresh), TH0);

`ifndef LIF_ADAPT_EN
        for (int v = 0; v < 6; v++) begin
            do_reset();
            write(0, tbl[v].cur);
            rd_addr = '0;
            spike_ready = 1'b1;
            repeat (tbl[v].sweeps) sweep();
            spike_ready = 1'b0;
            chk("tbl_state", int'(rd_state), tbl[v].exp_state);
            chk("tbl_spikes", popped.size(), tbl[v].exp_spikes);
        end

        // Saturation: state 187 with current 200 must clip to 255.
        do_reset();
        write(0, 100);
        sweep();
        sweep();
        chk("sat_pre", int'(rd_state), 187);
        write(0, 200);
        sweep();
        chk("sat_post", int'(rd_state), 255);

        // Timing, ignored mid-sweep start and write.
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t1_busy", int'(busy), 1);
        chk("t1_cur_ready", int'(cur_ready), 0);
        cur_valid = 1'b1;
        cur_addr = 2'd2;
        cur_data = 8'd99;
        for (int k = 1; k <= 4; k++) begin
            start = (k == 2);
            tick();
            chk("tk_done", int'(done), (k == 4) ? 1 : 0);
            chk("tk_busy", int'(busy), 1);
            chk("tk_cur_ready", int'(cur_ready), 0);
        end
        start = 1'b0;
        tick();
        cur_valid = 1'b0;
        chk("t6_busy", int'(busy), 0);
        chk("t6_done", int'(done), 0);
        tick();
        chk("t7_no_restart", int'(busy), 0);
        sweep();
        rd_addr = 2'd2;
        #1;
        chk("no_write_in_sweep", int'(rd_state), 0);

        // Write coincident with start is used by the same sweep.
        do_reset();
        cur_valid = 1'b1;
        cur_addr = '0;
        cur_data = 8'd60;
        start = 1'b1;
        tick();
        cur_valid = 1'b0;
        start = 1'b0;
        repeat (N + 1) tick();
        rd_addr = '0;
        #1;
        chk("write_with_start", int'(rd_state), 60);

        // FIFO fills with ids 0..3, then drops and sets overflow.
        do_reset();
        for (int i = 0; i < N; i++) write(i, 100);
        sweep();
        sweep();
        chk("fifo_full_no_ovf", int'(overflow), 0);
        sweep();
        chk("fifo_ovf", int'(overflow), 1);
        drain();
        chk("fifo_cnt", popped.size(), 4);
        for (int i = 0; i < 4; i++) chk("fifo_order", (i < popped.size()) ? popped[i] : -1, i);
        chk("ovf_sticky", int'(overflow), 1);

        // Push while full with a same-edge pop is accepted.
        do_reset();
        for (int i = 0; i < N; i++) write(i, 100);
        sweep();
        sweep();
        start = 1'b1;
        tick();
        start = 1'b0;
        spike_ready = 1'b1;
        repeat (N) tick();
        spike_ready = 1'b0;
        tick();
        chk("popfull_no_ovf", int'(overflow), 0);
        popped.delete();
        drain();
        chk("popfull_cnt", popped.size(), 4);
        for (int i = 0; i < 4; i++) chk("popfull_order", (i < popped.size()) ? popped[i] : -1, i);

        // Reset at T+2 aborts the sweep.
        do_reset();
        for (int i = 0; i < N; i++) write(i, 100);
        sweep();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("pre_abort_valid", int'(spike_valid), 1);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_valid", int'(spike_valid), 0);
        for (int i = 0; i < N; i++) begin
            rd_addr = AW'(i);
            #1;
            chk("abort_state", int'(rd_state), 0);
        end
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("abort_no_done", int'(done), 0);
        end
`else
        // Adaptation: decay to 103, then drive neuron 0 to spike at threshold 100.
        do_reset();
        rd_addr = '0;
        chk("ad_rst", int'(rd_thresh), 250);
        sweep();
        chk("ad_decay", int'(rd_thresh), 249);
        repeat (146) sweep();
        chk("ad_103", int'(rd_thresh), 103);
        write(0, 40);
        repeat (3) sweep();
        chk("ad_100", int'(rd_thresh), 100);
        chk("ad_state", int'(rd_state), 105);
        sweep();
        chk("ad_spike", int'(rd_thresh), 110);
`endif

        // Random traffic against the model.
        do_reset();
        for (int c = 0; c < 600; c++) begin
            reset_n     = ($urandom_range(0, 149) != 0);
            cur_valid   = ($urandom_range(0, 2) == 0);
            cur_addr    = AW'($urandom_range(0, N - 1));
            cur_data    = 8'($urandom_range(0, 255));
            start       = ($urandom_range(0, 3) == 0);
            spike_ready = ($urandom_range(0, 2) != 0);
            rd_addr     = AW'($urandom_range(0, N - 1));
            tick();
        end
        reset_n = 1'b1;
        cur_valid = 1'b0;
        start = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/lif_scheduler.md
LIF_SCHEDULER -- requirements
Module: lif_scheduler

Interface
REQ-001 SHALL have parameter NUM_NEURONS, default 4, giving the number of time-multiplexed neurons (power of two, 2..16).
REQ-002 SHALL have parameter BASE_THRESH, default 50, giving the resting spike threshold.
REQ-003 SHALL have parameter INIT_THRESH, default 250, giving the post-reset threshold when adaptation is compiled in.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, giving the spike-event FIFO depth (power of two).
REQ-005 SHALL have port clk, input, 1 bit: clock, rising edge.
REQ-006 SHALL have port reset_n, input, 1 bit: reset, synchronous, active-low.
REQ-007 SHALL have ports cur_valid (input, 1), cur_ready (output, 1), cur_addr (input, log2 NUM_NEURONS), cur_data (input, 8): current-write handshake.
REQ-008 SHALL have ports start (input, 1), busy (output, 1), done (output, 1): timestep control.
REQ-009 SHALL have ports spike_valid (output, 1), spike_ready (input, 1), spike_id (output, log2 NUM_NEURONS): spike-event stream.
REQ-010 SHALL have port overflow (output, 1): sticky spike-drop flag.
REQ-011 SHALL have ports rd_addr (input, log2 NUM_NEURONS), rd_state (output, 8), rd_thresh (output, 8): combinational debug read of the addressed neuron.

Function
REQ-012 SHALL hold per-neuron 8-bit current, membrane state and threshold registers.
REQ-013 SHALL implement FSM IDLE -> SWEEP -> DONE -> IDLE; busy = (FSM != IDLE); cur_ready = (FSM == IDLE).
REQ-014 SHALL write cur_data to current[cur_addr] on any edge with cur_valid and cur_ready high; writes outside IDLE are not accepted and do not complete.
REQ-015 SHALL, on start sampled high in IDLE at edge T, enter SWEEP with index 0; start outside IDLE is ignored, not queued.
REQ-016 SHALL, when start and an accepted write coincide, apply the write first so that the sweep uses the new current.
REQ-017 SHALL update neuron i at edge T+1+i: spike = (state >= thresh) on the pre-update state; next state = current + ((state*14)>>4), computed at 12 bits, saturated to 255.
REQ-018 SHALL enter DONE after the index NUM_NEURONS-1 update; done is high for exactly the one DONE cycle (cycle T+NUM_NEURONS+1), then IDLE.
REQ-019 SHALL retain currents across sweeps; currents change only by accepted writes.
REQ-020 SHALL push the neuron index into the spike FIFO on the same edge as a spiking update; spike_valid = FIFO not empty; spike_id = head entry; pop on spike_valid & spike_ready.
REQ-021 SHALL accept a push when the FIFO is full if a pop occurs on the same edge; otherwise SHALL drop the push and set overflow, which clears only on reset.
REQ-022 SHALL preserve FIFO ordering as ascending index within a sweep, and earlier sweeps before later ones.

Reset
REQ-023 SHALL, on reset_n low at an edge: FSM=IDLE, index=0, all currents=0, all states=0, FIFO empty, overflow=0, done=0; this takes effect mid-sweep and aborts the sweep with no done pulse.
REQ-024 SHALL reset all thresholds to INIT_THRESH when LIF_ADAPT_EN is defined, else to BASE_THRESH.

Configuration
REQ-025 SHALL, with macro LIF_ADAPT_EN defined, adapt the threshold per update: on spike, if thresh < 170 then thresh += current>>2, saturated to 255; on no spike, if thresh > BASE_THRESH then thresh -= 1.
REQ-026 SHALL, without LIF_ADAPT_EN, hold every threshold at BASE_THRESH with no adaptation logic present.

Verification
REQ-027 SHALL cover (no adapt) cur[0]=100, two sweeps -> sweep 1: no spike, rd_state=100; sweep 2: spike_id 0 emitted, rd_state=187.
REQ-028 SHALL cover saturation: state 187, current 200 -> next state 255 (not 107).
REQ-029 SHALL cover timing (NUM_NEURONS=4): start at edge T -> busy from T+1, done high only in cycle T+5, cur_ready low during T+1..T+5.
REQ-030 SHALL cover FIFO: spike_ready=0, all 4 neurons spiking for 2 sweeps -> 4 entries (ids 0,1,2,3) then overflow=1; pop-while-full push accepted without setting overflow.
REQ-031 SHALL cover reset mid-sweep: reset_n low at T+2 -> IDLE, states 0, FIFO empty, no done pulse.
REQ-032 SHALL cover (LIF_ADAPT_EN) reset -> rd_thresh=250; a non-spiking sweep -> 249; a spike with thresh 100 and current 40 -> 110.
